ac_pipe_ctrl: RTL and testbench

Sequencing controller for the AV1 arithmetic-encoder datapath (stage 1 → stage 2 + normalize → output).
- Accepts one symbol per cycle from the symbol source (FL, FH, SYMBOL, NSYMS travel alongside on the datapath, not through this block).
- Drives the register enables between stages and selects the initial range/low for the first symbol of a frame.
- Back-pressures on downstream stalls.
- At frame end, drains the pipe and runs the final-bits flush handshake.

---
 rtl/ac_pkg.sv | 16 +
 rtl/ac_pipe_ctrl.sv | 143 ++++++++++++++
 tb/tb_ac_pipe_ctrl.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ac_pkg.sv
// Shared types and constants for the AV1 arithmetic-encoder pipeline controller
// and the stage-2 initial range/low mux.
package ac_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        DRAIN = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [15:0] RANGE_INIT = 16'd32768;
    localparam logic [15:0] LOW_INIT   = 16'd0;

endpackage

// File: rtl/ac_pipe_ctrl.sv
// Sequencing controller for the arithmetic-encoder datapath: stage enables,
// first-symbol init select, downstream back-pressure and frame-end flush.
module ac_pipe_ctrl
    import ac_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 general_clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic                 in_ready,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic                 en_reg_1_2,
    output logic                 en_reg_2_3,
    output logic                 fb_load,
    output logic                 sel_init,
    output logic                 flush_req,
    input  logic                 flush_done,
    output logic                 frame_done,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] sym_count
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_v1;
    logic                 r_v2;
    logic                 r_first;
    logic [CNT_WIDTH-1:0] r_sym_count;

    logic                 w_adv;
    logic                 w_in_open;
    logic                 w_accept;
    logic                 w_v1_nxt;
    logic                 w_v2_nxt;

    // Both stage registers move together whenever the output slot is free or being drained.
    assign w_adv     = !r_v2 || out_ready;
    assign w_in_open = (r_state == IDLE) || (r_state == RUN);
    assign w_accept  = in_valid && in_ready;
    assign w_v1_nxt  = w_adv ? w_accept : r_v1;
    assign w_v2_nxt  = w_adv ? r_v1     : r_v2;

    assign in_ready   = w_in_open && w_adv;
    assign out_valid  = r_v2;
    assign en_reg_1_2 = w_adv;
    assign en_reg_2_3 = w_adv;
    assign fb_load    = r_v1 && w_adv;
    assign sel_init   = r_v1 && r_first;
    assign flush_req  = (r_state == FLUSH);
    assign frame_done = (r_state == DONE);
    assign busy       = (r_state != IDLE);
    assign sym_count  = r_sym_count;

    // Next-state logic; DRAIN looks at the post-edge valid bits so it leaves in the emptying cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = in_last ? DRAIN : RUN;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RUN: begin
                if (w_accept && in_last) begin
                    w_state_nxt = DRAIN;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            DRAIN: begin
                if (!w_v1_nxt && !w_v2_nxt) begin
                    w_state_nxt = FLUSH;
                end else begin
                    w_state_nxt = DRAIN;
                end
            end
            FLUSH: begin
                if (flush_done) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = FLUSH;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge general_clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Valid bits for reg_1_2 and reg_2_3.
    always_ff @(posedge general_clk or negedge reset) begin
        if (!reset) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
        end else begin
            r_v1 <= w_v1_nxt;
            r_v2 <= w_v2_nxt;
        end
    end

    // First-symbol marker: held while the frame's first symbol waits in reg_1_2.
    always_ff @(posedge general_clk or negedge reset) begin
        if (!reset) begin
            r_first <= 1'b0;
        end else if (w_accept && (r_state == IDLE)) begin
            r_first <= 1'b1;
        end else if (fb_load) begin
            r_first <= 1'b0;
        end else begin
            r_first <= r_first;
        end
    end

    // Accepted-symbol counter; restarts on a frame's first accept and saturates.
    always_ff @(posedge general_clk or negedge reset) begin
        if (!reset) begin
            r_sym_count <= '0;
        end else if (w_accept && (r_state == IDLE)) begin
            r_sym_count <= CNT_ONE;
        end else if (w_accept && (r_state == RUN) && (r_sym_count != CNT_MAX)) begin
            r_sym_count <= r_sym_count + CNT_ONE;
        end else begin
            r_sym_count <= r_sym_count;
        end
    end

endmodule

// File: tb/tb_ac_pipe_ctrl.sv
// Scoreboard bench for ac_pipe_ctrl: a small datapath model carries symbol ids
// through the enabled stage registers and a monitor checks every handshake.
module tb_ac_pipe_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_last;
    logic       out_ready;
    logic       flush_done;
    logic [7:0] in_data;

    logic        a_in_ready, a_out_valid, a_en12, a_en23, a_fb, a_sel;
    logic        a_flush_req, a_fd, a_busy;
    logic [15:0] a_cnt;
    logic        b_in_ready, b_out_valid, b_en12, b_en23, b_fb, b_sel;
    logic        b_flush_req, b_fd, b_busy;
    logic [1:0]  b_cnt;

    always #5 clk = ~clk;

    ac_pipe_ctrl #(.CNT_WIDTH(16)) u_dut (
        .general_clk(clk), .reset(reset), .in_valid(in_valid), .in_last(in_last),
        .in_ready(a_in_ready), .out_ready(out_ready), .out_valid(a_out_valid),
        .en_reg_1_2(a_en12), .en_reg_2_3(a_en23), .fb_load(a_fb), .sel_init(a_sel),
        .flush_req(a_flush_req), .flush_done(flush_done), .frame_done(a_fd),
        .busy(a_busy), .sym_count(a_cnt)
    );

    ac_pipe_ctrl #(.CNT_WIDTH(2)) u_dut_sat (
        .general_clk(clk), .reset(reset), .in_valid(in_valid), .in_last(in_last),
        .in_ready(b_in_ready), .out_ready(out_ready), .out_valid(b_out_valid),
        .en_reg_1_2(b_en12), .en_reg_2_3(b_en23), .fb_load(b_fb), .sel_init(b_sel),
        .flush_req(b_flush_req), .flush_done(flush_done), .frame_done(b_fd),
        .busy(b_busy), .sym_count(b_cnt)
    );

    typedef struct packed {
        logic [7:0] id;
        logic       first;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;
    int n_out = 0, n_fb = 0, n_sel = 0, n_fd = 0;

    logic [7:0] d12, d23;
    logic       f23;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Datapath model: stage registers follow the controller's enables.
    always @(posedge clk) begin
        if (a_en12) d12 <= in_data;
        if (a_en23) begin
            d23 <= d12;
            f23 <= a_sel;
        end
    end

    // Monitor: compare each delivered result against the scoreboard queue.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            if (a_fb)  n_fb++;
            if (a_sel) n_sel++;
            if (a_fd)  n_fd++;
            if (a_out_valid && out_ready) begin
                n_out++;
                chk("sb_nonempty", 32'(q.size() > 0), 32'd1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("result_id", 32'(d23), 32'(e.id));
                    chk("result_first", 32'(f23), 32'(e.first));
                end
            end
        end
    end

    task automatic check_idle(input string tag);
        chk({tag, "_in_ready"}, a_in_ready, 1);
        chk({tag, "_out_valid"}, a_out_valid, 0);
        chk({tag, "_fb_load"}, a_fb, 0);
        chk({tag, "_sel_init"}, a_sel, 0);
        chk({tag, "_flush_req"}, a_flush_req, 0);
        chk({tag, "_frame_done"}, a_fd, 0);
        chk({tag, "_en12"}, a_en12, 1);
        chk({tag, "_en23"}, a_en23, 1);
        chk({tag, "_busy"}, a_busy, 0);
        chk({tag, "_sym_count"}, a_cnt, 0);
        chk({tag, "_sym_count_sat"}, b_cnt, 0);
    endtask

    task automatic do_reset();
        in_valid = 1'b0; in_last = 1'b0; flush_done = 1'b0; out_ready = 1'b1; in_data = 8'd0;
        reset = 1'b0;
        @(posedge clk); #1;
        check_idle("rst");
        q.delete();
        reset = 1'b1;
        @(posedge clk); #1;
        check_idle("post_rst");
    endtask

    task automatic send_frame(input int n, input logic [7:0] base, output int cyc);
        cyc = 0;
        for (int i = 0; i < n; i++) begin
            bit acc;
            int w;
            acc = 1'b0;
            w = 0;
            in_valid = 1'b1;
            in_last  = (i == n - 1);
            in_data  = base + 8'(i);
            while (!acc && w < 40) begin
                @(negedge clk);
                acc = a_in_ready;
                if (acc) q.push_back(exp_t'{id: in_data, first: (i == 0)});
                @(posedge clk); #1;
                w++;
            end
            cyc += w;
            chk("accept_timeout", 32'(acc), 32'd1);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic finish_frame(input int exp_wait, input int exp_cnt, input int exp_sat, input int fd_delay);
        int w;
        w = 0;
        while (!a_flush_req && w < 40) begin
            chk("in_ready_closed", a_in_ready, 0);
            @(posedge clk); #1;
            w++;
        end
        chk("flush_wait", w, exp_wait);
        chk("flush_req_sat", b_flush_req, 1);
        chk("in_ready_flush", a_in_ready, 0);
        repeat (fd_delay) begin
            @(posedge clk); #1;
            chk("flush_req_hold", a_flush_req, 1);
        end
        flush_done = 1'b1;
        @(posedge clk); #1;
        flush_done = 1'b0;
        chk("frame_done", a_fd, 1);
        chk("frame_done_sat", b_fd, 1);
        chk("in_ready_done", a_in_ready, 0);
        chk("busy_done", a_busy, 1);
        @(posedge clk); #1;
        chk("frame_done_pulse", a_fd, 0);
        chk("busy_idle", a_busy, 0);
        chk("sym_count", a_cnt, exp_cnt);
        chk("sym_count_sat", b_cnt, exp_sat);
    endtask

    task automatic clear_counts();
        n_out = 0; n_fb = 0; n_sel = 0; n_fd = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        do_reset();

        // Reset with both stages full mid-frame.
        in_valid = 1'b1; in_last = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'h10 + 8'(i);
            @(negedge clk);
            if (a_in_ready) q.push_back(exp_t'{id: in_data, first: (i == 0)});
            @(posedge clk); #1;
        end
        chk("run_busy", a_busy, 1);
        chk("run_out_valid", a_out_valid, 1);
        chk("run_fb_load", a_fb, 1);
        do_reset();

        // Five-symbol frame; stray flush_done in IDLE is ignored.
        clear_counts();
        flush_done = 1'b1;
        @(posedge clk); #1;
        flush_done = 1'b0;
        chk("stray_flush_busy", a_busy, 0);
        chk("stray_flush_done", a_fd, 0);
        send_frame(5, 8'h30, cyc);
        chk("five_accept_cycles", cyc, 5);
        finish_frame(2, 5, 3, 1);
        chk("five_fb_count", n_fb, 5);
        chk("five_sel_count", n_sel, 1);
        chk("five_out_count", n_out, 5);
        chk("five_fd_count", n_fd, 1);

        // Three symbols with a four-cycle downstream stall on the first result.
        clear_counts();
        fork
            send_frame(3, 8'h20, cyc);
            begin
                int w;
                w = 0;
                while (!a_out_valid && w < 40) begin
                    @(posedge clk); #1;
                    w++;
                end
                chk("stall_start", a_out_valid, 1);
                out_ready = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    chk("stall_in_ready", a_in_ready, 0);
                    chk("stall_en12", a_en12, 0);
                    chk("stall_en23", a_en23, 0);
                    chk("stall_out_valid", a_out_valid, 1);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        finish_frame(2, 3, 3, 0);
        chk("stall_out_count", n_out, 3);
        chk("stall_fb_count", n_fb, 3);
        chk("stall_sel_count", n_sel, 1);

        // Single-symbol frame goes straight to DRAIN.
        clear_counts();
        send_frame(1, 8'h70, cyc);
        chk("single_busy", a_busy, 1);
        chk("single_in_ready", a_in_ready, 0);
        finish_frame(2, 1, 1, 0);
        chk("single_sel_count", n_sel, 1);
        chk("single_out_count", n_out, 1);

        // Back-to-back frames with the next symbol waiting through FLUSH/DONE.
        clear_counts();
        send_frame(2, 8'h40, cyc);
        in_valid = 1'b1; in_last = 1'b0; in_data = 8'h50;
        finish_frame(2, 2, 2, 1);
        send_frame(2, 8'h50, cyc);
        finish_frame(2, 2, 2, 0);
        chk("b2b_sel_count", n_sel, 2);
        chk("b2b_out_count", n_out, 4);

        // Six-symbol frame saturates the narrow counter.
        clear_counts();
        send_frame(6, 8'h60, cyc);
        finish_frame(2, 6, 3, 0);
        chk("six_out_count", n_out, 6);
        chk("six_fd_count", n_fd, 1);

        chk("sb_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
